// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite response codes and channel state encodings for axi4l_reg_bank.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi4l_reg_bank.sv
// AXI4-Lite slave with NUM_REGS byte-strobed control registers and per-register write pulses.
// Optional: define AXI4L_REG_BANK_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4l_reg_bank
  import axi4l_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           axi4l_aclk,
  input  logic                           axi4l_arstn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SPAN  = NUM_REGS * BYTES;

`ifdef AXI4L_REG_BANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  generate
    if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64))) begin : g_bad_dw
      $error("axi4l_reg_bank: DATA_WIDTH must be 32 or 64");
    end
    if ((NUM_REGS < 2) || (NUM_REGS > 256) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_nr
      $error("axi4l_reg_bank: NUM_REGS must be a power of 2 in 2..256");
    end
  endgenerate

  // Every address bit takes part, so aliases in the upper bits are out of range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < (ADDR_WIDTH+1)'(SPAN));
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   reg_wr_q;

  w_state_t              w_state_q, w_state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs_s, w_hs_s, have_aw_s, have_w_s, commit_s;
  logic [ADDR_WIDTH-1:0] cm_addr_s;
  logic [DATA_WIDTH-1:0] cm_data_s;
  logic [BYTES-1:0]      cm_strb_s;

  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs_s;

  assign aw_hs_s   = awvalid & awready_q;
  assign w_hs_s    = wvalid & wready_q;
  assign have_aw_s = aw_done_q | aw_hs_s;
  assign have_w_s  = w_done_q | w_hs_s;
  assign cm_addr_s = aw_hs_s ? awaddr : awaddr_q;
  assign cm_data_s = w_hs_s ? wdata : wdata_q;
  assign cm_strb_s = w_hs_s ? wstrb : wstrb_q;
  assign ar_hs_s   = arvalid & arready_q;

  // Write channel next state: capture AW/W in any order, commit once both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_done_d = 1'b1;
          awaddr_d  = awaddr;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (w_hs_s) begin
          w_done_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end else begin
          w_done_d = w_done_q;
        end
        if (have_aw_s && have_w_s) begin
          commit_s  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = in_range(cm_addr_s) ? RESP_OKAY : OOR_RESP;
          w_state_d = W_RESP;
        end else begin
          awready_d = ~have_aw_s;
          wready_d  = ~have_w_s;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
      end
    endcase
  end

  // Write channel state register.
  always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
    if (!axi4l_arstn) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Register array: byte-strobe merge and one-cycle commit pulse per register.
  always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
    if (!axi4l_arstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      reg_wr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_s && in_range(cm_addr_s) && (reg_idx(cm_addr_s) == IDX_W'(i))) begin
          for (int b = 0; b < BYTES; b++) begin
            if (cm_strb_s[b]) begin
              regs_q[i][b*8 +: 8] <= cm_data_s[b*8 +: 8];
            end
          end
          reg_wr_q[i] <= |cm_strb_s;
        end else begin
          reg_wr_q[i] <= 1'b0;
        end
      end
    end
  end

  // Read channel next state: data sampled from the array as held before the AR edge.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          if (in_range(araddr)) begin
            rdata_d = regs_q[reg_idx(araddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = OOR_RESP;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
      end
    endcase
  end

  // Read channel state register.
  always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
    if (!axi4l_arstn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
  endgenerate

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign reg_wr  = reg_wr_q;

endmodule
